mix_phase_ctrl: RTL and testbench

Phase-increment scheduler for the dual-channel receive mixer. It accepts host frequency words for mixer channel 0 and channel 1 into shadow registers. It applies them to the `phi0`/`phi1` mixer inputs only on a sample-boundary `tick`. It then holds a per-channel data-valid flag low for a settle window, so downstream decimators discard samples mixed with a half-updated NCO.

---
 rtl/mix_phase_ctrl.sv | 136 +++++++++++++
 tb/tb_mix_phase_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mix_phase_ctrl.sv
// Dual-channel mixer phase-increment scheduler: shadowed host writes,
// tick-aligned apply, per-channel settle masking of mix_valid.
module mix_phase_ctrl #(
   parameter int unsigned SETTLE_CYC = 8,
   parameter logic [31:0] RST_PHI    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic        cfg_ch,
   input  logic [31:0] cfg_phi,
   input  logic        tick,
   output logic [31:0] phi0,
   output logic [31:0] phi1,
   output logic [1:0]  mix_valid,
   output logic        busy,
   output logic [7:0]  upd_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PEND   = 2'd1,
      SETTLE = 2'd2
   } state_t;

   localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYC - 1);

   if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_settle
      $error("mix_phase_ctrl: SETTLE_CYC out of range 1..255");
   end

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  cnt;
   logic [7:0]  cnt_nxt;
   logic [1:0]  pend;
   logic [1:0]  pend_nxt;
   logic [1:0]  wr_mask;
   logic [1:0]  mv_nxt;
   logic [31:0] shadow0;
   logic [31:0] shadow1;
   logic [31:0] phi0_nxt;
   logic [31:0] phi1_nxt;
   logic [7:0]  upd_nxt;
   logic        wr;
   logic        apply;
   logic        rdy_nxt;
   logic        busy_nxt;

   assign wr      = cfg_valid & cfg_ready;
   assign wr_mask = {wr & cfg_ch, wr & ~cfg_ch};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SETTLE;
         cnt   <= CNT_LOAD;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      apply     = 1'b0;
      mv_nxt    = mix_valid;
      unique case (state)
         IDLE: begin
            if (wr) state_nxt = PEND;
         end
         PEND: begin
            if (tick) begin
               apply     = 1'b1;
               state_nxt = SETTLE;
               cnt_nxt   = CNT_LOAD;
               mv_nxt    = mix_valid & ~pend;
            end
         end
         SETTLE: begin
            if (cnt == 8'd0) begin
               mv_nxt    = 2'b11;
               state_nxt = (pend != 2'b00) ? PEND : IDLE;
            end else begin
               cnt_nxt = cnt - 8'd1;
            end
         end
         default: begin
            state_nxt = SETTLE;
            cnt_nxt   = CNT_LOAD;
         end
      endcase
   end

   // A write landing on the apply cycle re-arms its pend bit after the clear.
   always_comb begin
      pend_nxt = (apply ? 2'b00 : pend) | wr_mask;
      phi0_nxt = (apply & pend[0]) ? shadow0 : phi0;
      phi1_nxt = (apply & pend[1]) ? shadow1 : phi1;
      upd_nxt  = apply ? upd_cnt + 8'd1 : upd_cnt;
      rdy_nxt  = (state_nxt != SETTLE);
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow0 <= RST_PHI;
         shadow1 <= RST_PHI;
      end else begin
         if (wr_mask[0]) shadow0 <= cfg_phi;
         if (wr_mask[1]) shadow1 <= cfg_phi;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend      <= 2'b00;
         phi0      <= RST_PHI;
         phi1      <= RST_PHI;
         mix_valid <= 2'b00;
         upd_cnt   <= 8'd0;
         cfg_ready <= 1'b0;
         busy      <= 1'b1;
      end else begin
         pend      <= pend_nxt;
         phi0      <= phi0_nxt;
         phi1      <= phi1_nxt;
         mix_valid <= mv_nxt;
         upd_cnt   <= upd_nxt;
         cfg_ready <= rdy_nxt;
         busy      <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_mix_phase_ctrl.sv
// Directed bench for mix_phase_ctrl: vector table plus hand sequences
// for coincident write/tick, reset in PEND and upd_cnt wrap.
module tb_mix_phase_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_valid;
   logic        cfg_ready;
   logic        cfg_ch;
   logic [31:0] cfg_phi;
   logic        tick;
   logic [31:0] phi0;
   logic [31:0] phi1;
   logic [1:0]  mix_valid;
   logic        busy;
   logic [7:0]  upd_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mix_phase_ctrl #(
      .SETTLE_CYC(8),
      .RST_PHI   (32'h0000_0000)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_ch   (cfg_ch),
      .cfg_phi  (cfg_phi),
      .tick     (tick),
      .phi0     (phi0),
      .phi1     (phi1),
      .mix_valid(mix_valid),
      .busy     (busy),
      .upd_cnt  (upd_cnt)
   );

   typedef struct packed {
      logic [7:0]  n;
      logic        r;
      logic        v;
      logic        ch;
      logic [31:0] p;
      logic        tk;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [1:0]  emv;
      logic        erdy;
      logic        ebusy;
      logic [7:0]  eupd;
   } vec_t;

   localparam int NV = 16;
   vec_t tbl [NV];

   function automatic vec_t mk(
      input int n, input logic r, input logic v, input logic ch,
      input logic [31:0] p, input logic tk,
      input logic [31:0] e0, input logic [31:0] e1,
      input logic [1:0] emv, input logic erdy, input logic ebusy,
      input logic [7:0] eupd);
      vec_t t;
      t.n = 8'(n); t.r = r; t.v = v; t.ch = ch; t.p = p; t.tk = tk;
      t.e0 = e0; t.e1 = e1; t.emv = emv;
      t.erdy = erdy; t.ebusy = ebusy; t.eupd = eupd;
      return t;
   endfunction

   task automatic drive(input logic r, input logic v, input logic ch,
                        input logic [31:0] p, input logic tk);
      rst = r; cfg_valid = v; cfg_ch = ch; cfg_phi = p; tick = tk;
      @(negedge clk);
   endtask

   task automatic check(input string nm,
                        input logic [31:0] e0, input logic [31:0] e1,
                        input logic [1:0] emv, input logic erdy,
                        input logic ebusy, input logic [7:0] eupd);
      total++;
      if (phi0 !== e0 || phi1 !== e1 || mix_valid !== emv ||
          cfg_ready !== erdy || busy !== ebusy || upd_cnt !== eupd) begin
         bad++;
         $display("FAIL %s: got phi0=%h phi1=%h mv=%b rdy=%b busy=%b upd=%0d want phi0=%h phi1=%h mv=%b rdy=%b busy=%b upd=%0d",
                  nm, phi0, phi1, mix_valid, cfg_ready, busy, upd_cnt,
                  e0, e1, emv, erdy, ebusy, eupd);
      end
   endtask

   initial begin
      tbl[0]  = mk(2, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0);
      tbl[1]  = mk(7, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0);
      tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1, 0, 0);
      tbl[3]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 2'b11, 1, 0, 0);
      tbl[4]  = mk(1, 0, 1, 0, 32'h0A3D_70A4, 0, 0, 0, 2'b11, 1, 1, 0);
      tbl[5]  = mk(4, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1, 1, 0);
      tbl[6]  = mk(1, 0, 0, 0, 0, 1, 32'h0A3D_70A4, 0, 2'b10, 0, 1, 1);
      tbl[7]  = mk(7, 0, 0, 0, 0, 0, 32'h0A3D_70A4, 0, 2'b10, 0, 1, 1);
      tbl[8]  = mk(1, 0, 0, 0, 0, 0, 32'h0A3D_70A4, 0, 2'b11, 1, 0, 1);
      tbl[9]  = mk(1, 0, 1, 0, 32'h100, 0, 32'h0A3D_70A4, 0, 2'b11, 1, 1, 1);
      tbl[10] = mk(1, 0, 1, 1, 32'h200, 0, 32'h0A3D_70A4, 0, 2'b11, 1, 1, 1);
      tbl[11] = mk(1, 0, 1, 0, 32'h300, 0, 32'h0A3D_70A4, 0, 2'b11, 1, 1, 1);
      tbl[12] = mk(1, 0, 0, 0, 0, 1, 32'h300, 32'h200, 2'b00, 0, 1, 2);
      tbl[13] = mk(7, 0, 1, 1, 32'hDEAD_BEEF, 1, 32'h300, 32'h200, 2'b00, 0, 1, 2);
      tbl[14] = mk(1, 0, 1, 1, 32'hDEAD_BEEF, 1, 32'h300, 32'h200, 2'b11, 1, 0, 2);
      tbl[15] = mk(2, 0, 0, 0, 0, 1, 32'h300, 32'h200, 2'b11, 1, 0, 2);

      for (int i = 0; i < NV; i++) begin
         for (int k = 0; k < int'(tbl[i].n); k++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].ch, tbl[i].p, tbl[i].tk);
            check($sformatf("vec%0d.%0d", i, k), tbl[i].e0, tbl[i].e1,
                  tbl[i].emv, tbl[i].erdy, tbl[i].ebusy, tbl[i].eupd);
         end
      end

      // write coincident with an applying tick
      drive(0, 1, 1, 32'h44, 0);
      check("coin_wr", 32'h300, 32'h200, 2'b11, 1, 1, 2);
      drive(0, 1, 1, 32'h55, 1);
      check("coin_apply", 32'h300, 32'h44, 2'b01, 0, 1, 3);
      for (int k = 0; k < 7; k++) begin
         drive(0, 0, 0, 0, 0);
         check("coin_settle", 32'h300, 32'h44, 2'b01, 0, 1, 3);
      end
      drive(0, 0, 0, 0, 0);
      check("coin_pend", 32'h300, 32'h44, 2'b11, 1, 1, 3);
      drive(0, 0, 0, 0, 1);
      check("coin_apply2", 32'h300, 32'h55, 2'b01, 0, 1, 4);
      repeat (8) drive(0, 0, 0, 0, 0);
      check("coin_idle", 32'h300, 32'h55, 2'b11, 1, 0, 4);

      // reset while a write is pending
      drive(0, 1, 0, 32'hFFFF, 0);
      check("rst_pend", 32'h300, 32'h55, 2'b11, 1, 1, 4);
      drive(1, 1, 0, 32'h1234, 1);
      check("rst_hit", 0, 0, 2'b00, 0, 1, 0);
      for (int k = 0; k < 7; k++) begin
         drive(0, 0, 0, 0, 0);
         check("rst_settle", 0, 0, 2'b00, 0, 1, 0);
      end
      drive(0, 0, 0, 0, 0);
      check("rst_idle", 0, 0, 2'b11, 1, 0, 0);
      drive(0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 1);
      check("rst_noupd", 0, 0, 2'b11, 1, 0, 0);

      // 256 updates wrap upd_cnt
      for (int i = 0; i < 256; i++) begin
         drive(0, 1, i[0], 32'(i + 1), 0);
         drive(0, 0, 0, 0, 1);
         repeat (8) drive(0, 0, 0, 0, 0);
         if (i == 254)
            check("wrap_255", 32'd255, 32'd254, 2'b11, 1, 0, 8'd255);
      end
      check("wrap_0", 32'd255, 32'd256, 2'b11, 1, 0, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
